// File: rtl/formant_frame_sched.sv
// Frame scheduler in front of the formant estimator.
// A capture FSM collects one FFT magnitude frame into a single-frame buffer.
// An engine FSM replays that frame to the estimator as I back-to-back beats,
// then waits for completion under a watchdog that pulses the estimator reset
// if the estimator hangs. It also keeps saturating drop/timeout counters.
module formant_frame_sched #(
  parameter int BIT_WIDTH      = 32,
  parameter int I              = 160,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RST_CYCLES     = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 bin_valid,
  input  logic                 bin_first,
  input  logic [BIT_WIDTH-1:0] bin_data,
  output logic                 fmt_fft_valid,
  output logic [BIT_WIDTH-1:0] fmt_fft_data,
  output logic                 fmt_rst,
  input  logic                 fmt_formant_valid,
  output logic                 result_valid,
  output logic                 frame_dropped,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] timeout_count
);

  localparam int IDX_W = (I > 1) ? $clog2(I) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RC_W  = $clog2(RST_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(I - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {C_IDLE, C_FILL, C_FULL} cap_state_t;
  typedef enum logic [1:0] {E_IDLE, E_PLAY, E_WAIT, E_RECOVER} eng_state_t;

  typedef struct packed {
    logic                 en;
    logic [IDX_W-1:0]     addr;
    logic [BIT_WIDTH-1:0] data;
  } wr_req_t;

  cap_state_t c_state, c_next;
  eng_state_t e_state, e_next;

  logic [IDX_W-1:0] wr_idx, wr_idx_next;
  logic [IDX_W-1:0] rd_idx;
  logic [WD_W-1:0]  wd_cnt;
  logic [RC_W-1:0]  rc_cnt;
  logic             rel_pend;   // last replay read was issued last cycle
  wr_req_t          wr;
  logic             drop;
  logic             rd_en;
  logic             done;
  logic             tmo;

  logic [BIT_WIDTH-1:0] mem [I];

  // Capture next-state: buffer writes, frame aborts and overflow drops.
  always_comb begin
    c_next      = c_state;
    wr_idx_next = wr_idx;
    wr          = '0;
    drop        = 1'b0;
    case (c_state)
      C_IDLE: begin
        if (bin_valid && bin_first) begin
          wr.en       = 1'b1;
          wr.addr     = '0;
          wr.data     = bin_data;
          wr_idx_next = IDX_W'(1);
          c_next      = C_FILL;
        end
      end
      C_FILL: begin
        if (bin_valid) begin
          wr.en   = 1'b1;
          wr.data = bin_data;
          if (bin_first) begin
            // New frame header mid-fill: discard the partial frame, restart.
            drop        = 1'b1;
            wr.addr     = '0;
            wr_idx_next = IDX_W'(1);
          end else begin
            wr.addr     = wr_idx;
            wr_idx_next = wr_idx + IDX_W'(1);
            if (wr_idx == LAST_IDX) c_next = C_FULL;
          end
        end
      end
      C_FULL: begin
        // Buffer is owned by the frame held or being replayed; a new frame
        // header cannot be taken, including on the release cycle itself.
        if (bin_valid && bin_first) drop = 1'b1;
        if (rel_pend) c_next = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  // Capture state and write pointer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      c_state <= C_IDLE;
      wr_idx  <= '0;
    end else begin
      c_state <= c_next;
      wr_idx  <= wr_idx_next;
    end
  end

  // Frame buffer write port; contents need no reset.
  always_ff @(posedge clk_in) begin
    if (wr.en) mem[wr.addr] <= wr.data;
  end

  // Engine next-state: replay, completion wait, watchdog and recovery.
  always_comb begin
    e_next = e_state;
    rd_en  = 1'b0;
    done   = 1'b0;
    tmo    = 1'b0;
    case (e_state)
      E_IDLE: begin
        if (c_state == C_FULL && !rel_pend) e_next = E_PLAY;
      end
      E_PLAY: begin
        rd_en = 1'b1;
        if (rd_idx == LAST_IDX) e_next = E_WAIT;
      end
      E_WAIT: begin
        // Completion takes priority over a coincident timeout.
        if (fmt_formant_valid) begin
          done   = 1'b1;
          e_next = E_IDLE;
        end else if (wd_cnt == WD_LAST) begin
          tmo    = 1'b1;
          e_next = E_RECOVER;
        end
      end
      E_RECOVER: begin
        if (rc_cnt == RC_LAST) e_next = E_IDLE;
      end
      default: e_next = E_IDLE;
    endcase
  end

  // Engine state, read/watchdog/recovery counters and release flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      e_state  <= E_IDLE;
      rd_idx   <= '0;
      wd_cnt   <= '0;
      rc_cnt   <= '0;
      rel_pend <= 1'b0;
    end else begin
      e_state  <= e_next;
      rel_pend <= rd_en && (rd_idx == LAST_IDX);
      rd_idx   <= (e_state == E_PLAY && e_next == E_PLAY) ? rd_idx + IDX_W'(1) : '0;
      wd_cnt   <= (e_state == E_WAIT && e_next == E_WAIT) ? wd_cnt + WD_W'(1) : '0;
      rc_cnt   <= (e_state == E_RECOVER && e_next == E_RECOVER) ? rc_cnt + RC_W'(1) : '0;
    end
  end

  // Registered buffer read feeding the estimator beat stream.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fmt_fft_valid <= 1'b0;
      fmt_fft_data  <= '0;
    end else begin
      fmt_fft_valid <= rd_en;
      if (rd_en) fmt_fft_data <= mem[rd_idx];
    end
  end

  // Status pulses and saturating debug counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      result_valid  <= 1'b0;
      frame_dropped <= 1'b0;
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      result_valid  <= done;
      frame_dropped <= drop;
      if (drop && drop_count != '1)   drop_count    <= drop_count + CNT_WIDTH'(1);
      if (tmo && timeout_count != '1) timeout_count <= timeout_count + CNT_WIDTH'(1);
    end
  end

  assign fmt_rst = (e_state == E_RECOVER);
  assign busy    = (e_state != E_IDLE);

endmodule

// File: tb/tb_formant_frame_sched.sv
// Bench for formant_frame_sched: directed frames, a queue scoreboard of
// expected replay beats checked by a negedge monitor, and a small estimator
// model that answers a fixed number of cycles after the last replayed beat.
module tb_formant_frame_sched;
  localparam int BW   = 32;
  localparam int NB   = 8;
  localparam int TMO  = 50;
  localparam int RSTC = 2;
  localparam int CW   = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          bin_valid = 1'b0;
  logic          bin_first = 1'b0;
  logic [BW-1:0] bin_data = '0;
  logic          fmt_formant_valid = 1'b0;
  logic          fmt_fft_valid;
  logic [BW-1:0] fmt_fft_data;
  logic          fmt_rst;
  logic          result_valid;
  logic          frame_dropped;
  logic          busy;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] timeout_count;

  formant_frame_sched #(
    .BIT_WIDTH(BW), .I(NB), .TIMEOUT_CYCLES(TMO), .RST_CYCLES(RSTC), .CNT_WIDTH(CW)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .bin_valid(bin_valid), .bin_first(bin_first), .bin_data(bin_data),
    .fmt_fft_valid(fmt_fft_valid), .fmt_fft_data(fmt_fft_data),
    .fmt_rst(fmt_rst), .fmt_formant_valid(fmt_formant_valid),
    .result_valid(result_valid), .frame_dropped(frame_dropped), .busy(busy),
    .drop_count(drop_count), .timeout_count(timeout_count)
  );

  always #5 clk_in = ~clk_in;

  int            n_chk = 0;
  int            n_fail = 0;
  longint        cyc = 0;
  logic [BW-1:0] exp_q[$];
  int            beats_seen = 0;
  int            run_cnt = 0;
  int            drops_seen = 0;
  int            est_delay = 20;
  longint        last_beat_cyc = 0;
  longint        fv_at = -1;
  logic          fd_prev = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor: pops expected beats, checks run length and drop pulse width,
  // and arms the estimator model on the last beat of each frame.
  always @(negedge clk_in) begin
    if (rst_in) begin
      run_cnt = 0;
      fd_prev = 1'b0;
    end else begin
      if (fmt_fft_valid) begin
        beats_seen++;
        run_cnt++;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else chk("beat_data", fmt_fft_data, exp_q.pop_front());
        if (run_cnt > NB) fail_now("beat_run_too_long");
        if (run_cnt == NB && est_delay > 0) fv_at = cyc + est_delay;
      end else begin
        if (run_cnt != 0) chk("beat_run_len", run_cnt, NB);
        run_cnt = 0;
      end
      if (frame_dropped) begin
        drops_seen++;
        if (fd_prev) fail_now("drop_pulse_width");
      end
      fd_prev = frame_dropped;
      if (fmt_rst) fv_at = -1;
    end
  end

  // Estimator model output.
  initial forever begin
    @(posedge clk_in);
    #1;
    fmt_formant_valid = (fv_at >= 0) && (cyc == fv_at);
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_bin(input logic first, input logic [BW-1:0] d);
    bin_valid = 1'b1;
    bin_first = first;
    bin_data  = d;
    tick();
    bin_valid = 1'b0;
    bin_first = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps, input bit expect_it);
    for (int k = 0; k < NB; k++) begin
      send_bin(k == 0, BW'(base + k));
      if (expect_it) exp_q.push_back(BW'(base + k));
      if (gaps && $urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic wait_beats(input string name, input int target);
    int k;
    k = 0;
    while (beats_seen < target && k < 500) begin
      @(negedge clk_in);
      k++;
    end
    chk({name, "_beats"}, beats_seen, target);
  endtask

  task automatic wait_result(input string name, output longint at, output logic b);
    bit seen;
    seen = 0;
    at = -1;
    b = 1'b1;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk_in);
      if (result_valid) begin
        seen = 1;
        at = cyc;
        b = busy;
      end
    end
    chk({name, "_result_seen"}, seen, 1);
    if (seen) begin
      @(negedge clk_in);
      chk({name, "_result_pulse_w"}, result_valid, 0);
    end
  endtask

  task automatic wait_valid(input string name, output longint at);
    bit seen;
    seen = 0;
    at = -1;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk_in);
      if (fmt_fft_valid) begin
        seen = 1;
        at = cyc;
      end
    end
    chk({name, "_valid_seen"}, seen, 1);
  endtask

  task automatic wait_data(input string name, input logic [BW-1:0] d);
    bit seen;
    seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk_in);
      if (fmt_fft_valid && fmt_fft_data == d) seen = 1;
    end
    chk({name, "_data_seen"}, seen, 1);
  endtask

  initial begin
    longint rc, fb, w_last, rs;
    logic   bz;
    int     b0, n;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_fft_valid", fmt_fft_valid, 0);
    chk("rst_fmt_rst", fmt_rst, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_frame_dropped", frame_dropped, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_timeout_count", timeout_count, 0);
    rst_in = 1'b0;
    tick();

    // Normal frame with random gaps, then a second frame during E_WAIT
    send_frame(1, 1, 1);
    wait_beats("t1", 8);
    tick();
    send_frame(10, 0, 1);
    wait_result("t1", rc, bz);
    chk("t1_busy_at_result", bz, 0);
    wait_valid("t2", fb);
    chk("t2_idle_gap", fb - rc, 2);
    chk("t1_drop_count", drop_count, 0);
    wait_result("t2", rc, bz);
    tick();
    chk("t2_drop_count", drop_count, 0);
    chk("t2_busy_idle", busy, 0);

    // Overflow: estimator silent, three frames offered
    est_delay = 0;
    b0 = beats_seen;
    send_frame(30, 0, 1);
    wait_beats("t3", b0 + NB);
    w_last = last_beat_cyc;
    tick();
    send_frame(40, 0, 1);
    send_frame(50, 0, 0);
    chk("t3_drops_seen", drops_seen, 1);
    chk("t3_drop_count", drop_count, 1);

    // Watchdog timeout and estimator reset pulse
    rs = -1;
    for (int k = 0; k < 200 && rs < 0; k++) begin
      @(negedge clk_in);
      if (fmt_rst) rs = cyc;
    end
    chk("t4_rst_start", rs - w_last, TMO);
    est_delay = 20;
    n = (rs >= 0) ? 1 : 0;
    for (int k = 0; k < 10 && rs >= 0; k++) begin
      @(negedge clk_in);
      if (fmt_rst) n++;
      else break;
    end
    chk("t4_rst_len", n, RSTC);
    chk("t4_timeout_count", timeout_count, 1);
    wait_result("t4", rc, bz);
    chk("t4_drop_count", drop_count, 1);
    chk("t4_timeout_count_after", timeout_count, 1);

    // Abort partial frame at wr_idx=4
    tick();
    send_bin(1'b1, 60);
    send_bin(1'b0, 61);
    send_bin(1'b0, 62);
    send_bin(1'b0, 63);
    send_frame(70, 0, 1);
    chk("t5_drop_count", drop_count, 2);

    // Release edge: header on release cycle dropped, next cycle accepted
    wait_data("t6", 76);
    tick();
    send_bin(1'b1, 32'h99);
    send_frame(80, 0, 1);
    wait_result("t5", rc, bz);
    chk("t6_drop_count", drop_count, 3);
    chk("t6_drops_seen", drops_seen, 3);

    // Reset during replay beat 3
    wait_data("t7", 83);
    #2;
    rst_in = 1'b1;
    #1;
    chk("t7_rst_fft_valid", fmt_fft_valid, 0);
    chk("t7_rst_fft_data", fmt_fft_data, 0);
    chk("t7_rst_fmt_rst", fmt_rst, 0);
    chk("t7_rst_result_valid", result_valid, 0);
    chk("t7_rst_frame_dropped", frame_dropped, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_drop_count", drop_count, 0);
    chk("t7_rst_timeout_count", timeout_count, 0);
    exp_q.delete();
    fv_at = -1;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    tick();
    send_frame(90, 1, 1);
    wait_result("t7", rc, bz);
    tick();
    chk("t7_drop_count", drop_count, 0);
    chk("t7_timeout_count", timeout_count, 0);
    chk("t7_busy_idle", busy, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
